// File: rtl/dec_stream_if.sv
// dec_stream_if: code-in handshake plus decoded-output bundle for dec_stream.
//   slave  : the decoder's view (takes in_valid/code, drives everything else)
//   master : the producer/observer view
// Signals:
//   in_valid, in_ready, code[3:0]   code handshake from the encoder side
//   y[7:0], out_valid, zero_flag    decoded word, new-word pulse, vld=0 marker
//   busy                            word on display or codes buffered
interface dec_stream_if;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] code;
   logic [7:0] y;
   logic       out_valid;
   logic       zero_flag;
   logic       busy;

   modport slave  (input  in_valid, code,
                   output in_ready, y, out_valid, zero_flag, busy);
   modport master (output in_valid, code,
                   input  in_ready, y, out_valid, zero_flag, busy);
endinterface

// File: rtl/dec_stream.sv
// dec_stream: streaming 3-to-8 one-hot decoder with a 2-deep code buffer.
// Each accepted code {vld, idx} is shown on y for HOLD cycles (y = 1<<idx,
// or all-zero with zero_flag when vld=0). Queued words follow back-to-back.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   s      dec_stream_if.slave (in_valid/in_ready/code in, y/out_valid/
//          zero_flag/busy out)
module dec_stream #(
   parameter int unsigned HOLD = 4   // 1..255
) (
   input  logic          clk,
   input  logic          rst_n,
   dec_stream_if.slave   s
);

   localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);

   typedef enum logic {S_IDLE, S_HOLD} state_e;

   state_e          state_q, state_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [7:0]      y_q, y_d;
   logic            zero_q, zero_d;
   logic            ov_q, ov_d;

   logic [1:0][3:0] mem_q, mem_d;
   logic            wr_ptr_q, wr_ptr_d;
   logic            rd_ptr_q, rd_ptr_d;
   logic [1:0]      count_q, count_d;

   logic            push, pop;
   logic [3:0]      head;

   // Ready comes from registered count only; a full buffer stays not-ready
   // even on a cycle that pops.
   assign s.in_ready = (count_q != 2'd2);
   assign push       = s.in_valid & s.in_ready;
   assign head       = mem_q[rd_ptr_q];

   // FSM next-state, hold counter and output word
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      y_d     = y_q;
      zero_d  = zero_q;
      ov_d    = 1'b0;
      pop     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (count_q != 2'd0) begin
               pop     = 1'b1;
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (cnt_q == 8'd0) begin
               // last cycle of this word: chain the next one with no gap
               if (count_q != 2'd0) begin
                  pop = 1'b1;
               end else begin
                  state_d = S_IDLE;
                  y_d     = 8'h00;
                  zero_d  = 1'b0;
               end
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (pop) begin
         ov_d   = 1'b1;
         cnt_d  = HOLD_M1;
         y_d    = head[3] ? (8'b1 << head[2:0]) : 8'h00;
         zero_d = ~head[3];
      end
   end

   // FIFO bookkeeping
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = s.code;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= 8'd0;
         y_q      <= 8'h00;
         zero_q   <= 1'b0;
         ov_q     <= 1'b0;
         mem_q    <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         y_q      <= y_d;
         zero_q   <= zero_d;
         ov_q     <= ov_d;
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign s.y         = y_q;
   assign s.out_valid = ov_q;
   assign s.zero_flag = zero_q;
   assign s.busy      = (state_q == S_HOLD) || (count_q != 2'd0);

endmodule
